coord_store: RTL and testbench
==============================

# coord_store

Downstream stage of the coordinate collector in the pathfinding accelerator. Accepts (x, y) node coordinates over a valid/ready handshake and optionally rejects duplicates by sequential scan. Assigns each stored coordinate a dense node ID and holds it in an internal register array. Asserts `done` once the final coordinate is processed, and serves single-cycle-latency reads to the path-search core.

## Interface
- `COORD_W`, 16: width of each of x and y.
- `DEPTH`, 16: maximum stored nodes; power of two ≥ 2. `ID_W` = $clog2(DEPTH), derived locally.
- `clk` input 1: the single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream coordinate valid.
- `in_x` input COORD_W: x coordinate.
- `in_y` input COORD_W: y coordinate.
- `in_last` input 1: this coordinate is the final one (finish-init).
- `in_ready` output 1: block can accept a coordinate this cycle.
- `rd_en` input 1: read request.
- `rd_id` input ID_W: node ID to read.
- `rd_valid` output 1: registered; read data valid.
- `rd_x`, `rd_y` output COORD_W: registered read data.
- `count` output ID_W+1: number of stored nodes.
- `done` output 1: collection finished; sticky until reset.
- `overflow` output 1: sticky; a coordinate arrived while full and was dropped.
- `dup_err` output 1: sticky; a duplicate coordinate was dropped.

## Operation
- States: ACCEPT, SCAN, WRITE, FINISH. Reset state ACCEPT.
- `in_ready` = (state == ACCEPT). It is combinational from state only, never from `in_valid`.
- ACCEPT: on `in_valid && in_ready`, latch x, y and last, clear the scan index `idx`. Go to SCAN if `count` > 0, else WRITE.
- SCAN: compare `mem[idx]` with the latched pair, one entry per cycle.
  - Match: set `dup_err`, no write. Go to FINISH if last, else ACCEPT.
  - No match and `idx == count-1`: go to WRITE.
  - Otherwise: `idx++`.
- WRITE:
  - If `count == DEPTH`: set `overflow`, drop the coordinate, `count` unchanged.
  - Else: `mem[count]` <= pair and `count++`.
  - Then go to FINISH if last, else ACCEPT.
- FINISH: `done` = 1, `in_ready` = 0, all input ignored. Exits only via reset.
- A dropped coordinate (duplicate or overflow) that carries last still terminates collection.
- Read port:
  - Active in every state, independent of the write FSM.
  - On `rd_en`: if `rd_id < count`, then next cycle `rd_valid` = 1 and `rd_x`/`rd_y` = `mem[rd_id]`. Else `rd_valid` = 0 and data = 0.
  - Without `rd_en`: `rd_valid` = 0 next cycle, data holds.
  - Same-cycle read of the entry being written returns the old contents; `count` compares pre-increment.
- `mem` is not reset; only entries below `count` are ever visible.

## Timing
- Reset values: `in_ready` = 1 (state ACCEPT), `count` = 0, `done` = 0, `overflow` = 0, `dup_err` = 0, `rd_valid` = 0, `rd_x` = 0, `rd_y` = 0.
- Reset asserted mid-operation aborts immediately. Any in-flight coordinate is lost and the FSM returns to ACCEPT.
- Handshake at cycle T with N = `count`:
  - SCAN occupies T+1 .. T+N; WRITE is at T+N+1.
  - `count` and `in_ready` update at T+N+2; `done` rises at T+N+2 if last.
  - If N = 0, WRITE is at T+1.
- A duplicate found at `idx` = k returns to ACCEPT (or FINISH) at T+k+2.
- Read latency: exactly 1 cycle.

## Configuration
- `COORD_STORE_DEDUP_EN` defined:
  - SCAN state present; duplicates detected and dropped as above.
- Undefined:
  - SCAN state and `idx` removed; ACCEPT always goes to WRITE.
  - Every coordinate is written (duplicates allowed); `dup_err` is tied to 0.
  - Handshake at T gives `count` update and `in_ready` = 1 at T+2.

## Test plan
- Reset, then send (3,5), (7,1), (3,5 last) with DEDUP_EN → `count` = 2, `dup_err` = 1, `done` = 1, `in_ready` = 0. Read ID 1 → (7,1) one cycle later, `rd_valid` = 1.
- Same stimulus without DEDUP_EN → `count` = 3, `dup_err` = 0, ID 2 reads (3,5).
- DEPTH = 4: send 5 distinct coordinates, last on the 5th → `count` = 4, `overflow` = 1, `done` = 1, ID 3 holds the 4th coordinate.
- With `count` = 3 and DEDUP_EN, hold `in_valid` high → `in_ready` low for exactly 4 cycles after the handshake, high again at T+5, `count` = 4.
- Read `rd_id` = `count` and `rd_id` = `DEPTH-1` while partially full → `rd_valid` = 0, data = 0.
- Assert `reset` during SCAN with `count` = 2 → all outputs at reset values immediately. After release `count` = 0, and a new coordinate is accepted and written to ID 0.

Source files
------------

// File: rtl/coord_store.sv
// coord_store: collects (x, y) node coordinates over valid/ready, gives each
// stored pair a dense node ID and serves 1-cycle-latency reads.
// Optional feature macro: COORD_STORE_DEDUP_EN (sequential duplicate scan).
`timescale 1ns/1ps

module coord_store #(
  parameter int COORD_W = 16,
  parameter int DEPTH   = 16,
  localparam int ID_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               rd_en,
  input  logic [ID_W-1:0]    rd_id,
  output logic               rd_valid,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [ID_W:0]      count,
  output logic               done,
  output logic               overflow,
  output logic               dup_err
);

  localparam logic [ID_W:0]   FULL_CNT = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0]   CNT_ONE  = (ID_W+1)'(1);

`ifdef COORD_STORE_DEDUP_EN
  typedef enum logic [1:0] {ACCEPT = 2'd0, SCAN = 2'd1, WRITE = 2'd2, FINISH = 2'd3} state_t;
  localparam logic [ID_W-1:0] IDX_ONE  = ID_W'(1);
`else
  typedef enum logic [1:0] {ACCEPT = 2'd0, WRITE = 2'd2, FINISH = 2'd3} state_t;
`endif

  state_t state, state_next;

  logic [COORD_W-1:0] mem_x [DEPTH];
  logic [COORD_W-1:0] mem_y [DEPTH];
  logic [COORD_W-1:0] lat_x, lat_y;
  logic               lat_last;
  logic               full;
  logic               take;

  assign full     = (count == FULL_CNT);
  assign in_ready = (state == ACCEPT);
  assign done     = (state == FINISH);
  assign take     = in_ready && in_valid;

`ifdef COORD_STORE_DEDUP_EN
  logic [ID_W-1:0] idx;
  logic            hit;
  logic            scan_end;
  logic            dup_q;

  assign hit      = (mem_x[idx] == lat_x) && (mem_y[idx] == lat_y);
  assign scan_end = ({1'b0, idx} == (count - CNT_ONE));
  assign dup_err  = dup_q;
`else
  assign dup_err  = 1'b0;
`endif

  // State register; reset aborts any coordinate in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACCEPT;
    else        state <= state_next;
  end

  // Next-state logic: accept, optionally scan for duplicates, write, finish.
  always_comb begin
    state_next = state;
    case (state)
      ACCEPT: begin
        if (in_valid) begin
`ifdef COORD_STORE_DEDUP_EN
          state_next = (count != '0) ? SCAN : WRITE;
`else
          state_next = WRITE;
`endif
        end
      end
`ifdef COORD_STORE_DEDUP_EN
      SCAN: begin
        if (hit)           state_next = lat_last ? FINISH : ACCEPT;
        else if (scan_end) state_next = WRITE;
      end
`endif
      WRITE:   state_next = lat_last ? FINISH : ACCEPT;
      FINISH:  state_next = FINISH;
      default: state_next = ACCEPT;
    endcase
  end

  // Latched coordinate, scan index, node count and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_x    <= '0;
      lat_y    <= '0;
      lat_last <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef COORD_STORE_DEDUP_EN
      idx      <= '0;
      dup_q    <= 1'b0;
`endif
    end else begin
      if (take) begin
        lat_x    <= in_x;
        lat_y    <= in_y;
        lat_last <= in_last;
`ifdef COORD_STORE_DEDUP_EN
        idx      <= '0;
`endif
      end
`ifdef COORD_STORE_DEDUP_EN
      if (state == SCAN) begin
        if (hit)            dup_q <= 1'b1;
        else if (!scan_end) idx   <= idx + IDX_ONE;
      end
`endif
      if (state == WRITE) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + CNT_ONE;
      end
    end
  end

  // Node storage; deliberately not reset, entries at or above count are never exposed.
  always_ff @(posedge clk) begin
    if (state == WRITE && !full) begin
      mem_x[count[ID_W-1:0]] <= lat_x;
      mem_y[count[ID_W-1:0]] <= lat_y;
    end
  end

  // Read port: one-cycle latency, out-of-range IDs return invalid zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_id} < count) begin
        rd_valid <= 1'b1;
        rd_x     <= mem_x[rd_id];
        rd_y     <= mem_y[rd_id];
      end else begin
        rd_valid <= 1'b0;
        rd_x     <= '0;
        rd_y     <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coord_store.sv
// tb_coord_store: randomized and directed checks of coord_store against a
// list-based reference model (follows COORD_STORE_DEDUP_EN like the DUT).
`timescale 1ns/1ps

module tb_coord_store;

  localparam int COORD_W = 16;
  localparam int DEPTH   = 4;
  localparam int ID_W    = $clog2(DEPTH);
`ifdef COORD_STORE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [COORD_W-1:0] in_x, in_y;
  logic               in_last;
  logic               in_ready;
  logic               rd_en;
  logic [ID_W-1:0]    rd_id;
  logic               rd_valid;
  logic [COORD_W-1:0] rd_x, rd_y;
  logic [ID_W:0]      count;
  logic               done, overflow, dup_err;

  coord_store #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .in_ready(in_ready),
    .rd_en(rd_en), .rd_id(rd_id), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
    .count(count), .done(done), .overflow(overflow), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  // Reference model: the ordered list of stored pairs plus sticky flags.
  logic [COORD_W-1:0] mx [DEPTH];
  logic [COORD_W-1:0] my [DEPTH];
  int mcount;
  bit mdone, movf, mdup;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int modelFind(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    for (int i = 0; i < mcount; i++)
      if (mx[i] == x && my[i] == y) return i;
    return -1;
  endfunction

  task automatic modelClear();
    mcount = 0; mdone = 0; movf = 0; mdup = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_count"}, count, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_dup_err"}, dup_err, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid, 0);
    checkOutput({tag, "_rd_x"}, rd_x, 0);
    checkOutput({tag, "_rd_y"}, rd_y, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    in_valid = 0; in_last = 0; rd_en = 0;
    reset = 0;
    #1 checkResetValues("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    modelClear();
  endtask

  // One coordinate through the handshake, then measure the busy window.
  task automatic applyStimulus(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input bit last);
    int w, k, n, expLat;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    in_valid = 1; in_x = x; in_y = y; in_last = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_last = 0;
    k = modelFind(x, y);
    if (DEDUP && k >= 0) begin
      expLat = k + 2;
      mdup = 1;
    end else begin
      expLat = DEDUP ? mcount + 2 : 2;
      if (mcount == DEPTH) movf = 1;
      else begin
        mx[mcount] = x; my[mcount] = y; mcount++;
      end
    end
    if (last) mdone = 1;
    n = 0;
    while (!in_ready && !done && n < 60) begin n++; @(negedge clk); end
    checkOutput("busy_cycles", n, expLat - 1);
    checkOutput("count", count, mcount);
    checkOutput("dup_err", dup_err, mdup);
    checkOutput("overflow", overflow, movf);
    checkOutput("done", done, mdone);
    checkOutput("in_ready", in_ready, !mdone);
  endtask

  // Read one ID with 1-cycle latency, then confirm the idle cycle holds data.
  task automatic readCheck(input int id);
    logic [COORD_W-1:0] ex, ey;
    bit ev;
    ev = (id < mcount);
    ex = ev ? mx[id] : '0;
    ey = ev ? my[id] : '0;
    @(negedge clk);
    rd_en = 1; rd_id = ID_W'(id);
    @(negedge clk);
    rd_en = 0;
    checkOutput("rd_valid", rd_valid, ev);
    checkOutput("rd_x", rd_x, ex);
    checkOutput("rd_y", rd_y, ey);
    @(negedge clk);
    checkOutput("rd_valid_idle", rd_valid, 0);
    checkOutput("rd_x_hold", rd_x, ex);
    checkOutput("rd_y_hold", rd_y, ey);
  endtask

  task automatic checkIgnoredAfterDone();
    @(negedge clk);
    in_valid = 1; in_x = 16'h00AA; in_y = 16'h00BB; in_last = 0;
    repeat (3) @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    checkOutput("post_done_count", count, mcount);
    checkOutput("post_done_ready", in_ready, 0);
    checkOutput("post_done_done", done, 1);
  endtask

  initial begin
    int n;
    reset = 1; in_valid = 0; in_x = '0; in_y = '0; in_last = 0; rd_en = 0; rd_id = '0;
    modelClear();
    #2 reset = 0;
    #1 checkResetValues("por");
    @(negedge clk);
    reset = 1;

    // Directed: duplicate carrying last
    applyStimulus(3, 5, 0);
    applyStimulus(7, 1, 0);
    applyStimulus(3, 5, 1);
    readCheck(1);
    readCheck(2);
    checkIgnoredAfterDone();

    // Directed: fill, long scan window, out-of-range reads, overflow with last
    applyReset();
    applyStimulus(1, 1, 0);
    applyStimulus(2, 2, 0);
    readCheck(2);
    readCheck(DEPTH - 1);
    applyStimulus(3, 3, 0);
    applyStimulus(4, 4, 0);
    applyStimulus(5, 5, 1);
    readCheck(3);
    readCheck(0);

    // Randomized epochs with small coordinate ranges to provoke duplicates
    for (int e = 0; e < 8; e++) begin
      applyReset();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        applyStimulus(COORD_W'($urandom_range(0, 3)), COORD_W'($urandom_range(0, 2)), i == n - 1);
        if ($urandom_range(0, 1) == 1) readCheck($urandom_range(0, DEPTH - 1));
      end
      for (int id = 0; id < DEPTH; id++) readCheck(id);
    end

    // Reset while a coordinate is in flight
    applyReset();
    applyStimulus(10, 10, 0);
    applyStimulus(11, 11, 0);
    readCheck(1);
    @(negedge clk);
    in_valid = 1; in_x = 12; in_y = 12; in_last = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    reset = 0;
    #1 checkResetValues("mid_reset");
    @(negedge clk);
    reset = 1;
    modelClear();
    applyStimulus(20, 21, 0);
    readCheck(0);
    readCheck(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
